// File: rtl/axi4_lite_s_regs.sv
// rtl/axi4_lite_s_regs.sv - AXI4-Lite slave register file with exported contents and write pulses
// Optional feature macro: AXI4_LITE_S_SLVERR_EN (out-of-range accesses answer SLVERR instead of OKAY).
module axi4_lite_s_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_S_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    // Reject illegal configurations at elaboration time.
    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
            $fatal(1, "axi4_lite_s_regs: DATA_WIDTH must be 32 or 64");
        end
        if (NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
            $fatal(1, "axi4_lite_s_regs: NUM_REGS must be a power of two in 2..256");
        end
        if (ADDR_WIDTH < IDX_W + ADDR_LSB) begin : g_bad_addr_width
            $fatal(1, "axi4_lite_s_regs: ADDR_WIDTH too small for NUM_REGS");
        end
    endgenerate

    typedef enum logic [2:0] {
        W_IDLE,
        W_WAIT_A,
        W_WAIT_D,
        W_COMMIT,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    w_state_t                w_state;
    r_state_t                r_state;

    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_WIDTH-1:0]   w_strb_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic [IDX_W-1:0]        aw_idx;
    logic [IDX_W-1:0]        ar_idx;
    logic                    aw_in_range;
    logic                    ar_in_range;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // An address is in range when every bit above the register index is zero.
    assign aw_idx      = aw_addr_q[ADDR_LSB +: IDX_W];
    assign ar_idx      = ARADDR[ADDR_LSB +: IDX_W];
    assign aw_in_range = (aw_addr_q >> (ADDR_LSB + IDX_W)) == '0;
    assign ar_in_range = (ARADDR >> (ADDR_LSB + IDX_W)) == '0;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, AWPROT, ARPROT, aw_addr_q[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_q
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
        end
    endgenerate

    // Write channel FSM: collects AW and W in either order, commits once, then holds the response.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state   <= W_IDLE;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            reg_wr    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            reg_wr <= '0;
            case (w_state)
                W_IDLE: begin
                    // Readies drop for whichever channel handshakes; otherwise they
                    // (re)assert, which also covers the first edge after reset.
                    AWREADY <= !aw_hs;
                    WREADY  <= !w_hs;
                    if (aw_hs) begin
                        aw_addr_q <= AWADDR;
                    end
                    if (w_hs) begin
                        w_data_q <= WDATA;
                        w_strb_q <= WSTRB;
                    end
                    if (aw_hs && w_hs) begin
                        w_state <= W_COMMIT;
                    end else if (aw_hs) begin
                        w_state <= W_WAIT_D;
                    end else if (w_hs) begin
                        w_state <= W_WAIT_A;
                    end
                end
                W_WAIT_A: begin
                    if (aw_hs) begin
                        aw_addr_q <= AWADDR;
                        AWREADY   <= 1'b0;
                        w_state   <= W_COMMIT;
                    end
                end
                W_WAIT_D: begin
                    if (w_hs) begin
                        w_data_q <= WDATA;
                        w_strb_q <= WSTRB;
                        WREADY   <= 1'b0;
                        w_state  <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    // The write pulse fires for any in-range write, including an all-zero strobe.
                    if (aw_in_range) begin
                        for (int b = 0; b < STRB_WIDTH; b++) begin
                            if (w_strb_q[b]) begin
                                regs[aw_idx][8*b +: 8] <= w_data_q[8*b +: 8];
                            end
                        end
                        reg_wr[aw_idx] <= 1'b1;
                        BRESP          <= RESP_OKAY;
                    end else begin
                        BRESP          <= RESP_OOR;
                    end
                    BVALID  <= 1'b1;
                    w_state <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM: captures the addressed register on the AR handshake and holds it until taken.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RRESP   <= RESP_OKAY;
            RDATA   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ARREADY <= !ar_hs;
                    if (ar_hs) begin
                        RVALID <= 1'b1;
                        if (ar_in_range) begin
                            RDATA <= regs[ar_idx];
                            RRESP <= RESP_OKAY;
                        end else begin
                            RDATA <= '0;
                            RRESP <= RESP_OOR;
                        end
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        RVALID  <= 1'b0;
                        ARREADY <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_s_regs.sv
// tb/tb_axi4_lite_s_regs.sv - self-checking bench for axi4_lite_s_regs
module tb_axi4_lite_s_regs;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 8;
    localparam int FW = NR * DW;
`ifdef AXI4_LITE_S_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic          ACLK;
    logic          ARESETn;
    logic [AW-1:0] AWADDR;
    logic [2:0]    AWPROT;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic [2:0]    ARPROT;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;
    logic [FW-1:0] reg_q;
    logic [NR-1:0] reg_wr;

    axi4_lite_s_regs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_q(reg_q), .reg_wr(reg_wr)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc++;

    int wr_cnt [NR];
    always @(negedge ACLK) begin
        if (ARESETn) begin
            for (int i = 0; i < NR; i++) wr_cnt[i] += int'(reg_wr[i]);
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    strb;
        int            aw_dly;
        int            w_dly;
        int            b_dly;
        int            r_dly;
    } vec_t;

    typedef struct {
        logic [1:0]    resp;
        logic [NR-1:0] wr;
        logic [FW-1:0] q;
    } bexp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rexp_t;

    bexp_t b_q[$];
    rexp_t r_q[$];

    logic [DW-1:0] mdl [NR];
    int            exp_cnt [NR];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [3:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [FW-1:0] flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
        return f;
    endfunction

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        bexp_t      e;
        bexp_t      got;
        logic       ok_a;
        logic       ok_w;
        int         a_cyc;
        int         w_cyc;
        int         last_hs;
        int         n;
        logic [1:0] hold;
        e.wr = '0;
        if (addr < AW'(NR * 4)) begin
            mdl[addr[4:2]] = merge(mdl[addr[4:2]], data, strb);
            e.wr[addr[4:2]] = 1'b1;
            exp_cnt[addr[4:2]]++;
            e.resp = 2'b00;
        end else begin
            e.resp = OOR;
        end
        e.q = flat();
        b_q.push_back(e);
        ok_a = 1'b0;
        ok_w = 1'b0;
        a_cyc = 0;
        w_cyc = 0;
        fork
            begin
                repeat (aw_dly) @(negedge ACLK);
                AWADDR = addr;
                AWVALID = 1'b1;
                for (int k = 0; k < 40 && !ok_a; k++) begin
                    ok_a = AWREADY;
                    @(negedge ACLK);
                end
                AWVALID = 1'b0;
                a_cyc = cyc;
            end
            begin
                repeat (w_dly) @(negedge ACLK);
                WDATA = data;
                WSTRB = strb;
                WVALID = 1'b1;
                for (int k = 0; k < 40 && !ok_w; k++) begin
                    ok_w = WREADY;
                    @(negedge ACLK);
                end
                WVALID = 1'b0;
                w_cyc = cyc;
            end
        join
        check("aw_accept", ok_a, 1'b1);
        check("w_accept", ok_w, 1'b1);
        last_hs = (a_cyc > w_cyc) ? a_cyc : w_cyc;
        n = 0;
        while (!BVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("bvalid_seen", BVALID, 1'b1);
        if (BVALID) begin
            check("b_latency", cyc - last_hs, 1);
            got = b_q.pop_front();
            check("bresp", BRESP, got.resp);
            check("reg_wr_pulse", reg_wr, got.wr);
            check("reg_q_after_write", reg_q, got.q);
            hold = BRESP;
            for (int k = 0; k < b_dly; k++) begin
                @(negedge ACLK);
                check("b_hold", {BVALID, BRESP, AWREADY, WREADY, reg_wr}, {1'b1, hold, 2'b00, {NR{1'b0}}});
            end
            BREADY = 1'b1;
            @(negedge ACLK);
            BREADY = 1'b0;
            check("b_done", {BVALID, AWREADY, WREADY, reg_wr}, {1'b0, 2'b11, {NR{1'b0}}});
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly);
        rexp_t e;
        rexp_t got;
        logic  hs;
        int    hs_cyc;
        int    n;
        if (addr < AW'(NR * 4)) begin
            e.data = mdl[addr[4:2]];
            e.resp = 2'b00;
        end else begin
            e.data = '0;
            e.resp = OOR;
        end
        r_q.push_back(e);
        repeat (ar_dly) @(negedge ACLK);
        ARADDR = addr;
        ARVALID = 1'b1;
        hs = 1'b0;
        for (int k = 0; k < 40 && !hs; k++) begin
            hs = ARREADY;
            @(negedge ACLK);
        end
        ARVALID = 1'b0;
        hs_cyc = cyc;
        check("ar_accept", hs, 1'b1);
        n = 0;
        while (!RVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("rvalid_seen", RVALID, 1'b1);
        if (RVALID) begin
            check("r_latency", cyc - hs_cyc, 0);
            got = r_q.pop_front();
            check("rdata", RDATA, got.data);
            check("rresp", RRESP, got.resp);
            for (int k = 0; k < r_dly; k++) begin
                @(negedge ACLK);
                check("r_hold", {RVALID, RDATA, RRESP, ARREADY}, {1'b1, got.data, got.resp, 1'b0});
            end
            RREADY = 1'b1;
            @(negedge ACLK);
            RREADY = 1'b0;
            check("r_done", {RVALID, ARREADY}, 2'b01);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs [9];
        rexp_t re;
        rexp_t rg;

        vecs[0] = '{32'h0000_0004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0};
        vecs[1] = '{32'h0000_0008, 32'h11223344, 4'h5, 3, 0, 0, 0};
        vecs[2] = '{32'h0000_0000, 32'hA5A5A5A5, 4'hF, 0, 2, 5, 4};
        vecs[3] = '{32'h0000_001C, 32'h12345678, 4'hC, 1, 1, 1, 0};
        vecs[4] = '{32'h0000_0010, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 1};
        vecs[5] = '{32'h0000_0020, 32'h99999999, 4'hF, 0, 0, 0, 0};
        vecs[6] = '{32'h0000_0040, 32'h55555555, 4'hF, 2, 0, 3, 2};
        vecs[7] = '{32'h0000_000F, 32'h0BADF00D, 4'h3, 0, 1, 0, 0};
        vecs[8] = '{32'h0000_0008, 32'hAABBCCDD, 4'hA, 0, 0, 0, 0};

        for (int i = 0; i < NR; i++) begin
            mdl[i] = '0;
            exp_cnt[i] = 0;
        end
        ARESETn = 1'b0;
        AWADDR = '0; AWPROT = 3'b000; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARPROT = 3'b000; ARVALID = 1'b0; RREADY = 1'b0;

        repeat (3) @(negedge ACLK);
        check("reset_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, reg_wr}, '0);
        check("reset_regs", reg_q, '0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("ready_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Reset lands while an accepted write address waits for its data.
        AWADDR = 32'h0; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        check("aw_only_readies", {AWREADY, WREADY}, 2'b01);
        #2 ARESETn = 1'b0;
        #1;
        check("async_reset_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, reg_wr}, '0);
        WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("regs_after_mid_reset", reg_q, '0);
        check("ready_after_mid_reset", {AWREADY, WREADY, ARREADY, BVALID}, 4'b1110);

        for (int i = 0; i < 9; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly);
            if (i == 0) check("reg1_deadbeef", reg_q[63:32], 32'hDEADBEEF);
            if (i == 1) check("reg2_partial", reg_q[95:64], 32'h00220044);
            do_read(vecs[i].addr, 0, vecs[i].r_dly);
        end

        // Read of reg1 handshakes on the same edge as a commit to reg1.
        check("idle_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        AWADDR = 32'h4; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        re.data = mdl[1];
        re.resp = 2'b00;
        r_q.push_back(re);
        mdl[1] = 32'hCAFEF00D;
        exp_cnt[1]++;
        ARADDR = 32'h4; ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("conc_valids", {RVALID, BVALID}, 2'b11);
        rg = r_q.pop_front();
        check("conc_rdata_sb", RDATA, rg.data);
        check("conc_old_value", RDATA, 32'hDEADBEEF);
        check("conc_new_reg", reg_q[63:32], 32'hCAFEF00D);
        RREADY = 1'b1; BREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0; BREADY = 1'b0;
        do_read(32'h4, 0, 0);

        for (int i = 0; i < NR; i++) do_read(AW'(i * 4), i % 2, 0);
        do_read(32'h40, 1, 0);
        do_read(32'h20, 0, 0);

        for (int i = 0; i < NR; i++) check("wr_pulse_count", wr_cnt[i], exp_cnt[i]);
        check("final_regs", reg_q, flat());
        check("reg2_merged", reg_q[95:64], 32'hAA22CC44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
